// File: rtl/kc705_reset_seq.sv
// rtl/kc705_reset_seq.sv - KC705 power-on / lock-loss reset sequencer (optional lock-loss counter: KC705_RST_LOSS_CNT_EN)
module kc705_reset_seq #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP_CYCLES   = 16,
    parameter int DEBOUNCE_CYCLES    = 1000000
) (
    input  logic       ddr_clk_100MHz,
    input  logic       ddr_rst,
    input  logic       mmcms_locked,
    input  logic       EXT_SYS_RST,
    output logic       interconnect_rst,
    output logic       peripheral_rst,
    output logic       peripheral_aresetn,
    output logic       sys_ready,
    output logic [1:0] seq_state,
    output logic [7:0] lock_loss_count
);

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        STABLE = 2'd1,
        IC_REL = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam logic [19:0] LOCK_LAST = 20'(LOCK_STABLE_CYCLES - 1);
    localparam logic [19:0] GAP_LAST  = 20'(STAGE_GAP_CYCLES - 1);
    localparam logic [19:0] DB_LAST   = 20'(DEBOUNCE_CYCLES - 1);

    logic        lock_m, lock_s;
    logic        btn_m, btn_s;
    logic        btn_req;
    logic [19:0] db_cnt;
    state_t      state, state_n;
    logic [19:0] cnt, cnt_n;
    logic        go;

    // Two-flop synchronisers for the asynchronous lock status and pushbutton
    always_ff @(posedge ddr_clk_100MHz) begin
        if (ddr_rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
            btn_m  <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            lock_m <= mmcms_locked;
            lock_s <= lock_m;
            btn_m  <= EXT_SYS_RST;
            btn_s  <= btn_m;
        end
    end

    // Debounce: the button level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge ddr_clk_100MHz) begin
        if (ddr_rst) begin
            btn_req <= 1'b0;
            db_cnt  <= '0;
        end else if (btn_s == btn_req) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_req <= ~btn_req;
            db_cnt  <= '0;
        end else begin
            db_cnt <= db_cnt + 20'd1;
        end
    end

    assign go = lock_s & ~btn_req;

    // Sequencer state and shared interval counter
    always_ff @(posedge ddr_clk_100MHz) begin
        if (ddr_rst) begin
            state <= HOLD;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic; any loss of go drops straight back to HOLD and restarts qualification
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            HOLD: begin
                cnt_n = '0;
                if (go) state_n = STABLE;
            end
            STABLE: begin
                if (!go) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end else if (cnt == LOCK_LAST) begin
                    state_n = IC_REL;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 20'd1;
                end
            end
            IC_REL: begin
                if (!go) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end else if (cnt == GAP_LAST) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 20'd1;
                end
            end
            RUN: begin
                cnt_n = '0;
                if (!go) state_n = HOLD;
            end
            default: begin
                state_n = HOLD;
                cnt_n   = '0;
            end
        endcase
    end

    assign interconnect_rst   = (state == HOLD) || (state == STABLE);
    assign peripheral_rst     = (state != RUN);
    assign peripheral_aresetn = (state == RUN);
    assign sys_ready          = (state == RUN);
    assign seq_state          = state;

`ifdef KC705_RST_LOSS_CNT_EN
    logic [7:0] loss_cnt;

    // Any exit from a non-HOLD state while lock is low is a lock loss, even if the button also fired
    always_ff @(posedge ddr_clk_100MHz) begin
        if (ddr_rst) begin
            loss_cnt <= '0;
        end else if ((state != HOLD) && !lock_s && (loss_cnt != 8'hFF)) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end

    assign lock_loss_count = loss_cnt;
`else
    assign lock_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_kc705_reset_seq.sv
// tb/tb_kc705_reset_seq.sv - directed self-checking bench for kc705_reset_seq
module tb_kc705_reset_seq;

    logic       clk = 1'b0;
    logic       ddr_rst;
    logic       mmcms_locked;
    logic       ext_sys_rst;
    logic       interconnect_rst;
    logic       peripheral_rst;
    logic       peripheral_aresetn;
    logic       sys_ready;
    logic [1:0] seq_state;
    logic [7:0] lock_loss_count;

    int n_checks = 0;
    int n_fail   = 0;

    kc705_reset_seq #(
        .LOCK_STABLE_CYCLES(8),
        .STAGE_GAP_CYCLES  (4),
        .DEBOUNCE_CYCLES   (5)
    ) dut (
        .ddr_clk_100MHz    (clk),
        .ddr_rst           (ddr_rst),
        .mmcms_locked      (mmcms_locked),
        .EXT_SYS_RST       (ext_sys_rst),
        .interconnect_rst  (interconnect_rst),
        .peripheral_rst    (peripheral_rst),
        .peripheral_aresetn(peripheral_aresetn),
        .sys_ready         (sys_ready),
        .seq_state         (seq_state),
        .lock_loss_count   (lock_loss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int exp_loss(input int n);
`ifdef KC705_RST_LOSS_CNT_EN
        return (n > 255) ? 255 : n;
`else
        return 0;
`endif
    endfunction

    task automatic do_reset();
        ddr_rst      = 1'b1;
        mmcms_locked = 1'b0;
        ext_sys_rst  = 1'b0;
        step(3);
        ddr_rst = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        check("rst_ic",     interconnect_rst, 1);
        check("rst_pr",     peripheral_rst, 1);
        check("rst_aresetn", peripheral_aresetn, 0);
        check("rst_ready",  sys_ready, 0);
        check("rst_state",  seq_state, 0);
        check("rst_loss",   lock_loss_count, 0);

        // power-up: lock sampled at edge 0
        mmcms_locked = 1'b1;
        step(1);
        step(1);  check("pu_e1_state", seq_state, 0);
        step(1);  check("pu_e2_state", seq_state, 1);
        step(7);  check("pu_e9_ic", interconnect_rst, 1);
        step(1);  check("pu_e10_ic", interconnect_rst, 0);
                  check("pu_e10_state", seq_state, 2);
                  check("pu_e10_pr", peripheral_rst, 1);
        step(3);  check("pu_e13_pr", peripheral_rst, 1);
        step(1);  check("pu_e14_pr", peripheral_rst, 0);
                  check("pu_e14_aresetn", peripheral_aresetn, 1);
                  check("pu_e14_ready", sys_ready, 1);
                  check("pu_e14_state", seq_state, 3);

        // one-cycle lock glitch at edge 6 while in STABLE
        do_reset();
        mmcms_locked = 1'b1;
        step(1);
        step(5);
        mmcms_locked = 1'b0;
        step(1);
        mmcms_locked = 1'b1;
        step(1);  check("gl_e7_state", seq_state, 1);
        step(1);  check("gl_e8_state", seq_state, 0);
                  check("gl_e8_loss", lock_loss_count, exp_loss(1));
        step(1);  check("gl_e9_state", seq_state, 1);
        step(7);  check("gl_e16_state", seq_state, 1);
        step(1);  check("gl_e17_state", seq_state, 2);
        step(4);  check("gl_e21_state", seq_state, 3);
                  check("gl_e21_ready", sys_ready, 1);

        // lock loss in RUN
        mmcms_locked = 1'b0;
        step(1);
        step(1);  check("ll_f1_state", seq_state, 3);
                  check("ll_f1_ready", sys_ready, 1);
        step(1);  check("ll_f2_state", seq_state, 0);
                  check("ll_f2_ready", sys_ready, 0);
                  check("ll_f2_ic", interconnect_rst, 1);
                  check("ll_f2_pr", peripheral_rst, 1);
                  check("ll_f2_aresetn", peripheral_aresetn, 0);
                  check("ll_f2_loss", lock_loss_count, exp_loss(2));

        // repeated losses up to and past saturation
        for (int i = 3; i <= 302; i++) begin
            mmcms_locked = 1'b1;
            step(15);
            if (i == 3) check("ll_rerun_state", seq_state, 3);
            mmcms_locked = 1'b0;
            step(3);
            if (i == 254) check("ll_loss_254", lock_loss_count, exp_loss(254));
            if (i == 255) check("ll_loss_255", lock_loss_count, exp_loss(255));
        end
        check("ll_loss_sat", lock_loss_count, exp_loss(302));

        // button: short press ignored, long press resets, release reruns sequence
        do_reset();
        check("bt_rst_loss", lock_loss_count, 0);
        mmcms_locked = 1'b1;
        step(15);
        check("bt_run_state", seq_state, 3);
        ext_sys_rst = 1'b1;
        step(4);
        ext_sys_rst = 1'b0;
        step(8);
        check("bt_short_state", seq_state, 3);
        check("bt_short_ready", sys_ready, 1);
        check("bt_short_req", dut.btn_req, 0);
        ext_sys_rst = 1'b1;
        step(1);
        step(5);  check("bt_p5_req", dut.btn_req, 0);
        step(1);  check("bt_p6_req", dut.btn_req, 1);
                  check("bt_p6_state", seq_state, 3);
        step(1);  check("bt_p7_state", seq_state, 0);
                  check("bt_p7_ic", interconnect_rst, 1);
                  check("bt_p7_pr", peripheral_rst, 1);
                  check("bt_p7_ready", sys_ready, 0);
        step(2);
        ext_sys_rst = 1'b0;
        step(1);
        step(5);  check("bt_p15_req", dut.btn_req, 1);
                  check("bt_p15_state", seq_state, 0);
        step(1);  check("bt_p16_req", dut.btn_req, 0);
                  check("bt_p16_state", seq_state, 0);
        step(1);  check("bt_p17_state", seq_state, 1);
        step(12); check("bt_p29_state", seq_state, 3);
                  check("bt_p29_ready", sys_ready, 1);
                  check("bt_p29_loss", lock_loss_count, 0);

        // simultaneous button and lock drop during IC_REL
        do_reset();
        mmcms_locked = 1'b1;
        step(1);
        step(10); check("sim_e10_state", seq_state, 2);
        mmcms_locked = 1'b0;
        ext_sys_rst  = 1'b1;
        step(1);
        step(1);  check("sim_e12_state", seq_state, 2);
        step(1);  check("sim_e13_state", seq_state, 0);
                  check("sim_e13_loss", lock_loss_count, exp_loss(1));
        ext_sys_rst = 1'b0;
        step(8);
        check("sim_idle_state", seq_state, 0);

        // ddr_rst during IC_REL
        mmcms_locked = 1'b1;
        step(1);
        step(11); check("mr_ic_rel_state", seq_state, 2);
                  check("mr_pre_loss", lock_loss_count, exp_loss(1));
        ddr_rst = 1'b1;
        step(1);
        check("mr_state", seq_state, 0);
        check("mr_ic", interconnect_rst, 1);
        check("mr_pr", peripheral_rst, 1);
        check("mr_ready", sys_ready, 0);
        check("mr_loss", lock_loss_count, 0);
        ddr_rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
